// File: rtl/hilo_acc_unit.sv
// Hi/Lo register pair with single-cycle moves/loads and a two-stage
// multiply-accumulate/subtract path with sticky overflow and reserved-op flags.
module hilo_acc_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_HI = '0,
  parameter logic [WIDTH-1:0] RESET_LO = '0
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               op_valid,
  input  logic [2:0]         op,
  input  logic               uns,
  input  logic [WIDTH-1:0]   a,
  input  logic [2*WIDTH-1:0] prod,
  input  logic               ovf_clr,
  output logic               op_ready,
  output logic [WIDTH-1:0]   Hi,
  output logic [WIDTH-1:0]   Lo,
  output logic               done,
  output logic               ovf,
  output logic               err
);

  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_MTHI = 3'b001,
    OP_MTLO = 3'b010,
    OP_LOAD = 3'b011,
    OP_MADD = 3'b100,
    OP_MSUB = 3'b101,
    OP_CLR  = 3'b110,
    OP_RSVD = 3'b111
  } op_t;

  typedef enum logic {IDLE, ACC} state_t;

  state_t        state, state_nxt;
  op_t           op_cur;
  logic          accept;
  logic [AW-1:0] stg_prod;
  logic          stg_sub;
  logic          stg_uns;
  logic [AW-1:0] acc_cur;
  logic [AW:0]   acc_ext;
  logic          sgn_ovf;
  logic          acc_set;
  logic          commit_1c;
  logic          ovf_clear_req;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    op_cur    = op_t'(op);
    op_ready  = (state == IDLE);
    accept    = op_valid && op_ready;
    state_nxt = state;
    case (state)
      IDLE: if (accept && (op_cur == OP_MADD || op_cur == OP_MSUB)) state_nxt = ACC;
      ACC:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Extra top bit carries the unsigned carry-out (add) or borrow (sub).
  always_comb begin
    acc_cur = {Hi, Lo};
    if (stg_sub) acc_ext = {1'b0, acc_cur} - {1'b0, stg_prod};
    else         acc_ext = {1'b0, acc_cur} + {1'b0, stg_prod};
    if (stg_sub)
      sgn_ovf = (acc_cur[AW-1] != stg_prod[AW-1]) && (acc_ext[AW-1] != acc_cur[AW-1]);
    else
      sgn_ovf = (acc_cur[AW-1] == stg_prod[AW-1]) && (acc_ext[AW-1] != acc_cur[AW-1]);
    acc_set       = (state == ACC) && (stg_uns ? acc_ext[AW] : sgn_ovf);
    commit_1c     = accept && (op_cur == OP_MTHI || op_cur == OP_MTLO ||
                               op_cur == OP_LOAD || op_cur == OP_CLR);
    ovf_clear_req = ovf_clr || (accept && op_cur == OP_CLR);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      Hi       <= RESET_HI;
      Lo       <= RESET_LO;
      stg_prod <= '0;
      stg_sub  <= 1'b0;
      stg_uns  <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= commit_1c || (state == ACC);
      if (acc_set)            ovf <= 1'b1;
      else if (ovf_clear_req) ovf <= 1'b0;
      if (state == ACC) begin
        {Hi, Lo} <= acc_ext[AW-1:0];
      end else if (accept) begin
        case (op_cur)
          OP_MTHI: Hi <= a;
          OP_MTLO: Lo <= a;
          OP_LOAD: {Hi, Lo} <= prod;
          OP_MADD, OP_MSUB: begin
            stg_prod <= prod;
            stg_sub  <= (op_cur == OP_MSUB);
            stg_uns  <= uns;
          end
          OP_CLR: begin
            Hi <= '0;
            Lo <= '0;
          end
          OP_RSVD: err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Directed bench for hilo_acc_unit (WIDTH=32) with hand-computed expectations.
module tb_hilo_acc_unit;

  logic        Clk;
  logic        Rst;
  logic        op_valid;
  logic [2:0]  op;
  logic        uns;
  logic [31:0] a;
  logic [63:0] prod;
  logic        ovf_clr;
  logic        op_ready;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        done;
  logic        ovf;
  logic        err;

  int tests  = 0;
  int failed = 0;

  hilo_acc_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .op_valid(op_valid), .op(op), .uns(uns), .a(a),
    .prod(prod), .ovf_clr(ovf_clr), .op_ready(op_ready), .Hi(Hi), .Lo(Lo),
    .done(done), .ovf(ovf), .err(err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic u, input logic [31:0] av,
                       input logic [63:0] p);
    op_valid = 1'b1;
    op       = o;
    uns      = u;
    a        = av;
    prod     = p;
    tick();
    op_valid = 1'b0;
  endtask

  initial begin
    Rst = 1'b1; op_valid = 1'b0; op = 3'b000; uns = 1'b0; a = '0; prod = '0; ovf_clr = 1'b0;
    tick();
    chk("rst_hilo", {Hi, Lo}, 64'h0);
    chk("rst_flags", {61'h0, done, ovf, err}, 64'h0);
    chk("rst_ready", {63'h0, op_ready}, 64'h1);
    Rst = 1'b0;
    tick();

    // carry between halves
    issue(3'b001, 1'b0, 32'h0000_0000, 64'h0);
    chk("mthi_done", {63'h0, done}, 64'h1);
    issue(3'b010, 1'b0, 32'hFFFF_FFFF, 64'h0);
    chk("mtlo_val", {Hi, Lo}, 64'h0000_0000_FFFF_FFFF);
    issue(3'b100, 1'b1, 32'h0, 64'h1);
    chk("madd_busy", {62'h0, op_ready, done}, 64'h0);
    chk("madd_hold", {Hi, Lo}, 64'h0000_0000_FFFF_FFFF);
    tick();
    chk("madd_carry", {Hi, Lo}, 64'h0000_0001_0000_0000);
    chk("madd_commit", {61'h0, done, op_ready, ovf}, 64'h6);
    tick();
    chk("done_pulse", {63'h0, done}, 64'h0);

    // unsigned borrow vs signed
    issue(3'b110, 1'b0, 32'h0, 64'h0);
    chk("clr", {Hi, Lo}, 64'h0);
    chk("clr_done", {63'h0, done}, 64'h1);
    issue(3'b101, 1'b1, 32'h0, 64'h1);
    tick();
    chk("msub_u_val", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("msub_u_ovf", {63'h0, ovf}, 64'h1);
    issue(3'b110, 1'b0, 32'h0, 64'h0);
    chk("clr_ovf", {63'h0, ovf}, 64'h0);
    issue(3'b101, 1'b0, 32'h0, 64'h1);
    tick();
    chk("msub_s_val", {Hi, Lo}, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("msub_s_ovf", {63'h0, ovf}, 64'h0);

    // signed overflow, LOAD leaves ovf, set beats clear
    issue(3'b011, 1'b0, 32'h0, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("load_val", {Hi, Lo}, 64'h7FFF_FFFF_FFFF_FFFF);
    issue(3'b100, 1'b0, 32'h0, 64'h1);
    tick();
    chk("sovf_val", {Hi, Lo}, 64'h8000_0000_0000_0000);
    chk("sovf_flag", {63'h0, ovf}, 64'h1);
    issue(3'b011, 1'b0, 32'h0, 64'h8000_0000_0000_0000);
    chk("load_keeps_ovf", {63'h0, ovf}, 64'h1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", {63'h0, ovf}, 64'h0);
    ovf_clr = 1'b1;
    issue(3'b100, 1'b0, 32'h0, 64'h8000_0000_0000_0000);
    tick();
    ovf_clr = 1'b0;
    chk("set_wins_val", {Hi, Lo}, 64'h0);
    chk("set_wins_ovf", {63'h0, ovf}, 64'h1);

    // backpressure: MADD held valid for 3 cycles
    issue(3'b110, 1'b0, 32'h0, 64'h0);
    op_valid = 1'b1; op = 3'b100; uns = 1'b1; prod = 64'h2;
    tick();
    chk("bp_c1", {Hi, Lo, 63'h0, op_ready}, {64'h0, 64'h0});
    tick();
    chk("bp_c2", {Hi, Lo}, 64'h2);
    chk("bp_c2_flags", {62'h0, op_ready, done}, 64'h3);
    tick();
    op_valid = 1'b0;
    chk("bp_c3_busy", {63'h0, op_ready}, 64'h0);
    tick();
    chk("bp_final", {Hi, Lo}, 64'h4);
    chk("bp_final_done", {63'h0, done}, 64'h1);

    // reserved opcode
    issue(3'b111, 1'b0, 32'h1234_5678, 64'hFFFF);
    chk("rsvd_state", {Hi, Lo}, 64'h4);
    chk("rsvd_flags", {62'h0, err, done}, 64'h2);
    issue(3'b001, 1'b0, 32'hDEAD_BEEF, 64'h0);
    chk("mthi_keeps_lo", {Hi, Lo}, 64'hDEAD_BEEF_0000_0004);
    chk("err_sticky", {63'h0, err}, 64'h1);

    // reset with MADD in flight, and op offered while in reset
    issue(3'b100, 1'b1, 32'h0, 64'h5);
    #2 Rst = 1'b1;
    #1;
    chk("arst_hilo", {Hi, Lo}, 64'h0);
    chk("arst_flags", {60'h0, op_ready, done, ovf, err}, 64'h8);
    op_valid = 1'b1; op = 3'b001; a = 32'h0000_0001;
    tick();
    chk("rst_discard", {Hi, Lo}, 64'h0);
    Rst = 1'b0;
    op_valid = 1'b0;
    tick();
    chk("post_rst", {Hi, Lo, 61'h0, op_ready, done, ovf}, {64'h0, 64'h4});
    tick();
    chk("post_rst_nodone", {63'h0, done}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/hilo_acc_unit.md
HILO_ACC_UNIT -- requirements
Module: hilo_acc_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: width of each of Hi and Lo; the accumulator is 2*WIDTH.
REQ-002 The block SHALL have parameter RESET_HI, default 0: Hi value on reset.
REQ-003 The block SHALL have parameter RESET_LO, default 0: Lo value on reset.
REQ-004 The block SHALL have port Clk, input, 1: single clock; all state updates on its posedge.
REQ-005 The block SHALL have port Rst, input, 1: asynchronous, active-high reset.
REQ-006 The block SHALL have port op_valid, input, 1: an operation is offered this cycle.
REQ-007 The block SHALL have port op, input, 3: opcode; encoding per REQ-014.
REQ-008 The block SHALL have port uns, input, 1: unsigned accumulate, sampled with op.
REQ-009 The block SHALL have port a, input, WIDTH: source operand for MTHI/MTLO.
REQ-010 The block SHALL have port prod, input, 2*WIDTH: 64-bit-class product for LOAD/MADD/MSUB.
REQ-011 The block SHALL have port ovf_clr, input, 1: clears the sticky ovf flag.
REQ-012 The block SHALL have outputs op_ready (1: op accepted this cycle if valid), Hi and Lo (WIDTH each: architectural registers), done (1: one-cycle commit pulse), ovf (1: sticky accumulate overflow) and err (1: sticky reserved-opcode flag).

Function
REQ-013 An op SHALL be accepted only on a posedge where op_valid=1 and op_ready=1; all other offered ops SHALL be ignored, with no state change.
REQ-014 The opcodes SHALL be:
- 000 NOP
- 001 MTHI: Hi<=a
- 010 MTLO: Lo<=a
- 011 LOAD: {Hi,Lo}<=prod
- 100 MADD: {Hi,Lo}+=prod
- 101 MSUB: {Hi,Lo}-=prod
- 110 CLR: Hi,Lo,ovf<=0
- 111 reserved
REQ-015 NOP, MTHI, MTLO, LOAD and CLR SHALL commit on the accepting edge (1-cycle latency); the unwritten register SHALL hold.
REQ-016 MADD/MSUB SHALL be two-stage; the controller SHALL have states IDLE and ACC.
REQ-017 In IDLE, on accepting MADD/MSUB: capture prod, add/sub select and uns into the stage register, then go to ACC.
REQ-018 In ACC: compute {Hi,Lo}+/-staged prod modulo 2^(2*WIDTH), write Hi/Lo, update ovf, then return to IDLE.
REQ-019 op_ready SHALL be 1 in IDLE and 0 in ACC (combinational from state), so back-to-back MADDs SHALL issue at most every 2 cycles.
REQ-020 In ACC, the addend SHALL be the Hi/Lo value at the ACC edge, i.e. including any commit made on the accepting edge (none is possible, since the accepting op is the MADD itself).
REQ-021 done SHALL be registered and pulse high for exactly one cycle after each commit edge:
- the accept edge for 1-cycle ops other than NOP/reserved
- the ACC edge for MADD/MSUB
REQ-022 ovf SHALL be computed from the staged uns value:
- uns=1: set on carry-out of MADD or borrow of MSUB
- uns=0: set on two's-complement signed overflow of the 2*WIDTH result
ovf SHALL be sticky and set only in ACC.
REQ-023 ovf SHALL clear on ovf_clr=1 or on accepting CLR; if set and clear occur on the same edge, set SHALL win.
REQ-024 An accepted op=111 SHALL behave as NOP, set err (sticky), and produce no done pulse; err SHALL clear only on reset.
REQ-025 LOAD SHALL not change ovf; MTHI/MTLO SHALL not change ovf.
REQ-026 All arithmetic SHALL be a full-width 2*WIDTH add/subtract with an extra carry bit; no truncation before compare.

Reset
REQ-027 Rst=1 SHALL asynchronously force:
- Hi=RESET_HI, Lo=RESET_LO
- state=IDLE, stage register=0
- done=0, ovf=0, err=0
REQ-028 Reset SHALL take effect immediately, independent of Clk.
REQ-029 Reset asserted while in ACC SHALL abort the accumulate with no partial write; op_ready SHALL be 1 on the first edge after Rst deasserts.
REQ-030 Any op offered on the edge where Rst is high SHALL be discarded.

Verification (WIDTH=32)
REQ-031 Reset: Rst pulse with MADD in flight -> Hi=0, Lo=0, ovf=0, err=0, op_ready=1; no done pulse afterwards.
REQ-032 Carry between halves:
- MTHI a=0, then MTLO a=0xFFFFFFFF, then MADD prod=1, uns=1
- response: Hi=0x00000001, Lo=0x00000000 two edges after MADD accept; done high one cycle; op_ready low one cycle; ovf=0
REQ-033 Unsigned borrow vs signed:
- CLR, then MSUB prod=1, uns=1 -> Hi=Lo=0xFFFFFFFF, ovf=1
- repeat with uns=0 after CLR -> same value, ovf=0
REQ-034 Signed overflow:
- LOAD prod=0x7FFFFFFF_FFFFFFFF, then MADD prod=1, uns=0
- response: Hi=0x80000000, Lo=0, ovf=1
- then ovf_clr on the same edge as a second overflowing MADD's ACC -> ovf stays 1
REQ-035 Backpressure and reserved opcode:
- op_valid held with MADD prod=2 for 3 cycles from {0,0} -> exactly one accepted in first 2 cycles, second accepted on cycle 3; Hi:Lo=4 after completion
- op=111 -> state unchanged, err=1, no done
